// File: rtl/calculator_pkg.sv
// Shared types for the calculator sequencing controller.
// Saturating arithmetic is enabled with CALC_SATURATE_EN.
package calculator_pkg;

  localparam int OPERAND_WIDTH = 4;

  typedef enum logic [1:0] {
    S_ENTER_A = 2'd0,
    S_WAIT_OP = 2'd1,
    S_ENTER_B = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/calculator_press_detect.sv
// Rising-edge press detector for debounced button levels.
// Prev registers reset high so a held button needs a release first.
module calculator_press_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] level,
  output logic [N-1:0] press
);

  logic [N-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '1;
    end else begin
      prev <= level;
    end
  end

  assign press = level & ~prev;

endmodule

// File: rtl/calculator_control.sv
// Operand/operator/operand sequencer with add/sub accumulator.
// Define CALC_SATURATE_EN to clamp results instead of wrapping.
module calculator_control
  import calculator_pkg::*;
#(
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 button_clr,
  input  logic                 button_ent,
  input  logic                 button_add,
  input  logic                 button_sub,
  input  logic                 slider_1,
  input  logic                 slider_2,
  input  logic                 slider_3,
  input  logic                 slider_4,
  output logic [ACC_WIDTH-1:0] acc,
  output logic [3:0]           operand,
  output state_t               state,
  output op_t                  op_sel,
  output logic                 overflow,
  output logic                 result_valid
);

  localparam int W = ACC_WIDTH + 1;

  logic [3:0]           press;
  logic [3:0]           act;
  logic [W-1:0]         ext;
  logic [W-1:0]         sum;
  logic [W-1:0]         diff;
  logic [ACC_WIDTH-1:0] res;
  logic                 flag;

  assign operand = {slider_4, slider_3, slider_2, slider_1};

  calculator_press_detect #(
    .N(4)
  ) u_press (
    .clk  (clk),
    .reset(reset),
    .level({button_sub, button_add, button_ent, button_clr}),
    .press(press)
  );

  // Only the highest-priority press survives: clr > ent > add > sub.
  always_comb begin
    act = '0;
    if (press[0])      act[0] = 1'b1;
    else if (press[1]) act[1] = 1'b1;
    else if (press[2]) act[2] = 1'b1;
    else if (press[3]) act[3] = 1'b1;
  end

  assign ext  = {{(W-OPERAND_WIDTH){1'b0}}, operand};
  assign sum  = {1'b0, acc} + ext;
  assign diff = {1'b0, acc} - ext;

  always_comb begin
    if (op_sel == OP_SUB) begin
      flag = diff[ACC_WIDTH];
      res  = diff[ACC_WIDTH-1:0];
`ifdef CALC_SATURATE_EN
      if (flag) res = '0;
`endif
    end else begin
      flag = sum[ACC_WIDTH];
      res  = sum[ACC_WIDTH-1:0];
`ifdef CALC_SATURATE_EN
      if (flag) res = '1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      state        <= S_ENTER_A;
      op_sel       <= OP_ADD;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (1'b1)
        act[0]: begin
          acc      <= '0;
          overflow <= 1'b0;
          op_sel   <= OP_ADD;
          state    <= S_ENTER_A;
        end
        act[1]: begin
          unique case (state)
            S_ENTER_A: begin
              acc      <= {{(ACC_WIDTH-OPERAND_WIDTH){1'b0}}, operand};
              overflow <= 1'b0;
              state    <= S_WAIT_OP;
            end
            S_ENTER_B: begin
              acc          <= res;
              overflow     <= overflow | flag;
              result_valid <= 1'b1;
              state        <= S_WAIT_OP;
            end
            default: ;
          endcase
        end
        act[2], act[3]: begin
          if (state != S_ENTER_A) begin
            op_sel <= act[3] ? OP_SUB : OP_ADD;
            state  <= S_ENTER_B;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calculator_control.sv
// Scoreboard bench for calculator_control against a behavioural model.
module tb_calculator_control;
  import calculator_pkg::*;

  localparam int AW  = 8;
  localparam int MAX = 1 << AW;

  localparam logic [3:0] B_CLR = 4'b0001;
  localparam logic [3:0] B_ENT = 4'b0010;
  localparam logic [3:0] B_ADD = 4'b0100;
  localparam logic [3:0] B_SUB = 4'b1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          button_clr, button_ent, button_add, button_sub;
  logic          slider_1, slider_2, slider_3, slider_4;
  logic [AW-1:0] acc;
  logic [3:0]    operand;
  state_t        state;
  op_t           op_sel;
  logic          overflow;
  logic          result_valid;

  calculator_control #(.ACC_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .button_clr  (button_clr),
    .button_ent  (button_ent),
    .button_add  (button_add),
    .button_sub  (button_sub),
    .slider_1    (slider_1),
    .slider_2    (slider_2),
    .slider_3    (slider_3),
    .slider_4    (slider_4),
    .acc         (acc),
    .operand     (operand),
    .state       (state),
    .op_sel      (op_sel),
    .overflow    (overflow),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     acc;
    state_t st;
    op_t    op;
    logic   ovf;
    logic   rv;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests  = 0;
  int   failed = 0;

  // Reference model: calculator behaviour in plain integers.
  int         m_acc;
  state_t     m_state;
  op_t        m_op;
  logic       m_ovf;
  logic       m_rv;
  logic [3:0] m_prev;

  task automatic model_reset();
    m_acc = 0; m_state = S_ENTER_A; m_op = OP_ADD;
    m_ovf = 1'b0; m_rv = 1'b0; m_prev = 4'b1111;
  endtask

  task automatic model_step(input logic [3:0] lv, input int opnd);
    logic [3:0] p;
    int r;
    p = lv & ~m_prev;
    m_prev = lv;
    m_rv = 1'b0;
    if (p[0]) begin
      m_acc = 0; m_ovf = 1'b0; m_op = OP_ADD; m_state = S_ENTER_A;
    end else if (p[1]) begin
      if (m_state == S_ENTER_A) begin
        m_acc = opnd; m_ovf = 1'b0; m_state = S_WAIT_OP;
      end else if (m_state == S_ENTER_B) begin
        if (m_op == OP_ADD) begin
          r = m_acc + opnd;
          if (r >= MAX) begin
            m_ovf = 1'b1;
`ifdef CALC_SATURATE_EN
            r = MAX - 1;
`else
            r = r - MAX;
`endif
          end
        end else begin
          r = m_acc - opnd;
          if (r < 0) begin
            m_ovf = 1'b1;
`ifdef CALC_SATURATE_EN
            r = 0;
`else
            r = r + MAX;
`endif
          end
        end
        m_acc = r; m_rv = 1'b1; m_state = S_WAIT_OP;
      end
    end else if (p[2] || p[3]) begin
      if (m_state != S_ENTER_A) begin
        m_op = p[2] ? OP_ADD : OP_SUB;
        m_state = S_ENTER_B;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic [3:0] lv, input logic [3:0] opnd);
    exp_t x;
    @(negedge clk);
    {button_sub, button_add, button_ent, button_clr} = lv;
    {slider_4, slider_3, slider_2, slider_1} = opnd;
    model_step(lv, int'(opnd));
    x.acc = m_acc; x.st = m_state; x.op = m_op;
    x.ovf = m_ovf; x.rv = m_rv;
    exp_q.push_back(x);
    #1 chk("operand", int'(operand), int'(opnd));
  endtask

  task automatic tap(input logic [3:0] lv, input logic [3:0] opnd);
    cyc(lv, opnd);
    cyc(4'b0000, opnd);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered output cycle against the model.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (int'(acc) != e.acc || state != e.st || op_sel != e.op ||
          overflow != e.ovf || result_valid != e.rv) begin
        failed++;
        $display("FAIL cycle t=%0t: acc=%0d/%0d state=%0d/%0d op=%0d/%0d ovf=%0b/%0b rv=%0b/%0b",
                 $time, acc, e.acc, state, e.st, op_sel, e.op,
                 overflow, e.ovf, result_valid, e.rv);
      end
    end
  end

  initial begin
    reset = 1'b1;
    {button_sub, button_add, button_clr} = 3'b000;
    button_ent = 1'b1;
    {slider_4, slider_3, slider_2, slider_1} = 4'd5;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_acc", int'(acc), 0);
    chk("reset_state", int'(state), int'(S_ENTER_A));
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_rv", int'(result_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    // ent held through reset is not a press
    repeat (3) cyc(B_ENT, 4'd5);
    settle();
    chk("held_ent_state", int'(state), int'(S_ENTER_A));
    cyc(4'b0000, 4'd5);
    tap(B_ENT, 4'd5);
    settle();
    chk("first_ent_acc", int'(acc), 5);
    chk("first_ent_state", int'(state), int'(S_WAIT_OP));

    // 9 + 6 then - 3
    tap(B_CLR, 4'd0);
    tap(B_ENT, 4'd9);
    tap(B_ADD, 4'd0);
    tap(B_ENT, 4'd6);
    settle();
    chk("add_acc", int'(acc), 15);
    chk("add_state", int'(state), int'(S_WAIT_OP));
    tap(B_SUB, 4'd0);
    tap(B_ENT, 4'd3);
    settle();
    chk("chain_sub_acc", int'(acc), 12);

    // 250 + 9
    tap(B_CLR, 4'd0);
    tap(B_ENT, 4'd15);
    repeat (15) begin
      tap(B_ADD, 4'd0);
      tap(B_ENT, 4'd15);
    end
    tap(B_ADD, 4'd0);
    tap(B_ENT, 4'd10);
    settle();
    chk("acc_250", int'(acc), 250);
    chk("no_ovf_250", int'(overflow), 0);
    tap(B_ADD, 4'd0);
    tap(B_ENT, 4'd9);
    settle();
`ifdef CALC_SATURATE_EN
    chk("add_ovf_acc", int'(acc), 255);
`else
    chk("add_ovf_acc", int'(acc), 3);
`endif
    chk("add_ovf_flag", int'(overflow), 1);

    // 2 - 5
    tap(B_CLR, 4'd0);
    tap(B_ENT, 4'd2);
    tap(B_SUB, 4'd0);
    tap(B_ENT, 4'd5);
    settle();
`ifdef CALC_SATURATE_EN
    chk("sub_borrow_acc", int'(acc), 0);
`else
    chk("sub_borrow_acc", int'(acc), 253);
`endif
    chk("sub_borrow_flag", int'(overflow), 1);

    // clr, ent and add together in S_ENTER_B
    tap(B_CLR, 4'd0);
    tap(B_ENT, 4'd4);
    tap(B_ADD, 4'd0);
    cyc(B_CLR | B_ENT | B_ADD, 4'd3);
    settle();
    chk("coinc_acc", int'(acc), 0);
    chk("coinc_state", int'(state), int'(S_ENTER_A));
    chk("coinc_rv", int'(result_valid), 0);
    cyc(4'b0000, 4'd3);

    // asynchronous reset mid-sequence
    tap(B_CLR, 4'd0);
    tap(B_ENT, 4'd7);
    tap(B_ADD, 4'd0);
    settle();
    chk("pre_reset_state", int'(state), int'(S_ENTER_B));
    #1 reset = 1'b1;
    #1;
    chk("async_acc", int'(acc), 0);
    chk("async_state", int'(state), int'(S_ENTER_A));
    chk("async_ovf", int'(overflow), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [3:0] lv;
      lv[0] = ($urandom_range(0, 19) == 0);
      lv[1] = ($urandom_range(0, 2) == 0);
      lv[2] = ($urandom_range(0, 3) == 0);
      lv[3] = ($urandom_range(0, 3) == 0);
      cyc(lv, 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/calculator_control.md
# calculator_control

Sequencing controller for the calculator datapath. Consumes the debounced button levels and four debounced slider bits produced by `calculator_input`, detects button presses, and walks a three-state operand/operator/operand sequence. Add and subtract results land in an accumulator that feeds the display logic. Sits directly between `calculator_input` and the display driver.

## Interface

Parameters:
- `ACC_WIDTH`, 8: accumulator width in bits; must be at least 5.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `button_clr`  in  1  debounced clear level.
- `button_ent`  in  1  debounced enter level.
- `button_add`  in  1  debounced add level.
- `button_sub`  in  1  debounced subtract level.
- `slider_1`..`slider_4`  in  1 each  debounced operand bits; `slider_1` is the LSB.
- `acc`  out  ACC_WIDTH  accumulator / displayed value.
- `operand`  out  4  live operand `{slider_4,slider_3,slider_2,slider_1}` for display.
- `state`  out  2  current controller state (package enum).
- `op_sel`  out  1  latched operator: 0 = add, 1 = sub.
- `overflow`  out  1  sticky carry/borrow flag.
- `result_valid`  out  1  one-cycle pulse when a computed result is written.

## Operation

- **Press detection:**
  - Per button, a previous-level register, reset to 1.
  - Press = level & ~prev.
  - A button held through reset therefore registers no press until it is released and pressed again.
- **Priority:** when presses coincide in one cycle, only the highest-priority press acts; the others are discarded.
  - Order: clr > ent > add > sub.
- **States:**
  - **S_ENTER_A:**
    - ent → acc = zero-extended operand, overflow = 0 → S_WAIT_OP.
    - add or sub → ignored.
  - **S_WAIT_OP:**
    - add → op_sel = 0 → S_ENTER_B.
    - sub → op_sel = 1 → S_ENTER_B.
    - ent → ignored.
  - **S_ENTER_B:**
    - add or sub → op_sel is overwritten; stays in S_ENTER_B.
    - ent → acc = acc ± zero-extended operand, result_valid = 1 → S_WAIT_OP, which allows chained operations.
- **clr in any state:** acc = 0, overflow = 0, op_sel = 0 → S_ENTER_A.
- **Arithmetic:**
  - Computed at ACC_WIDTH+1 bits.
  - Add: bit ACC_WIDTH set → overflow is set and stays set until the next clr or ent in S_ENTER_A.
  - Sub: a borrow (operand > acc) likewise sets overflow.
  - Without saturation the result wraps modulo 2^ACC_WIDTH.
- **Outputs:** `operand` is combinational from the sliders; all other outputs are registered.

## Timing

- **Reset values:**
  - acc = 0, state = S_ENTER_A, op_sel = 0, overflow = 0, result_valid = 0.
  - All prev registers = 1.
- **Press latency:**
  - The action takes effect on the first rising `clk` edge at which the level is 1 and prev is 0.
  - Outputs are updated immediately after that edge.
- **result_valid:** high for exactly the one cycle following the compute edge, aligned with the new acc.
- **Operand sampling:** the operand is sampled on the same edge as the ent press; slider changes on other cycles have no effect.
- **Asserting reset mid-sequence:**
  - All registers return to their reset values immediately.
  - Deasserting reset with no button held gives S_ENTER_A on the next cycle.
- A level held high produces exactly one press.

## Configuration

- Macro: `CALC_SATURATE_EN`.
- **Defined:**
  - Add overflow clamps acc to 2^ACC_WIDTH−1.
  - Sub borrow clamps acc to 0.
  - overflow is still set.
- **Undefined:** results wrap modulo 2^ACC_WIDTH as described.

## Structure

- **`calculator_pkg`:**
  - `state_t` enum: S_ENTER_A = 0, S_WAIT_OP = 1, S_ENTER_B = 2.
  - `op_t` enum: OP_ADD = 0, OP_SUB = 1.
  - Operand width constant `OPERAND_WIDTH = 4`.
- **Sub-module `calculator_press_detect`:**
  - Parameterised on the number of buttons.
  - Holds the prev registers and produces press pulses.
  - Instantiated once with 4 buttons.
- The FSM, arithmetic and saturation logic stay in `calculator_control`.

## Test plan

- Hold ent across reset release, release it, press again with operand 5 → no action while held; acc = 5, state = S_WAIT_OP after the second press.
- Operand 9 + ent, add, operand 6 + ent → acc = 15, result_valid high for 1 cycle, state = S_WAIT_OP; then sub, operand 3 + ent → acc = 12.
- ACC_WIDTH = 8, acc = 250, add 9 → wrap: acc = 3, overflow = 1; with `CALC_SATURATE_EN`: acc = 255, overflow = 1.
- acc = 2, sub 5 → wrap: acc = 253, overflow = 1; with `CALC_SATURATE_EN`: acc = 0, overflow = 1.
- clr, ent and add rising in the same cycle while in S_ENTER_B → acc = 0, state = S_ENTER_A, no result_valid.
- Assert reset while in S_ENTER_B with acc = 7 → acc = 0, state = S_ENTER_A, overflow = 0 within the same cycle, asynchronously.
